// File: rtl/cpu_pkg.sv
// Shared CPU types: decode-to-fetch mode encoding, Thumb NOP and the
// prefetch FIFO entry layout.
package cpu_pkg;

  typedef enum logic [1:0] {
    MODE_STALL  = 2'd0,
    MODE_RUN    = 2'd1,
    MODE_BRANCH = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_FETCH,
    ST_FLUSH
  } fetch_state_t;

  localparam logic [15:0] THUMB_NOP = 16'hBF00;

  typedef struct packed {
    logic [31:0] pc;
    logic [15:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch_entry_t; a synchronous clear wins over a push in
// the same cycle. The caller never pushes when full or pops when empty.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;

  // NOTE: non-blocking assignments for all clocked state, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // NOTE: the storage array has no reset; pointers and count alone define
  // which entries are valid, so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: in-order halfword reads into a prefetch FIFO,
// one instruction per cycle to decode. Define FETCH_STATS_EN for counters.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  i_mode,
  input  logic [31:0] i_branch_target,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [15:0] i_imem_rdata,
  output logic [15:0] o_ir_r,
  output logic        o_ir_valid_r,
  output logic [31:0] o_pc_r
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] o_stat_fetched_r,
  output logic [15:0] o_stat_flush_r
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t  state;
  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  logic          grant, is_branch, drop_rsp, accept_rsp, do_push, do_pop;
  logic [CW-1:0] out_next, drop_next, drop_branch;

  // The FIFO-plus-outstanding bound is what keeps pushes from overflowing.
  assign o_imem_req = !rst && (state == ST_FETCH)
                   && (({1'b0, fifo_count} + {1'b0, outstanding}) < (CW+1)'(FIFO_DEPTH))
                   && (outstanding < CW'(MAX_OUTSTANDING));
  assign o_imem_addr = pc;

  // NOTE: every always_comb output is assigned on every path, so no latches.
  always_comb begin
    grant       = o_imem_req && i_imem_gnt;
    is_branch   = (state != ST_BOOT) && (i_mode == MODE_BRANCH);
    drop_rsp    = i_imem_rvalid && (drop != '0);
    accept_rsp  = i_imem_rvalid && (drop == '0) && (outstanding != '0);
    do_push     = accept_rsp && !is_branch;
    do_pop      = !is_branch && (i_mode == MODE_RUN) && (fifo_count != '0);
    out_next    = outstanding + CW'(grant) - CW'(accept_rsp);
    drop_next   = drop - CW'(drop_rsp);
    drop_branch = drop_next + out_next;
    // Responses return in order, so the oldest outstanding address trails pc.
    push_entry.pc    = pc - 32'({outstanding, 1'b0});
    push_entry.instr = i_imem_rdata;
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (is_branch),
    .push      (do_push),
    .push_data (push_entry),
    .pop       (do_pop),
    .head      (head),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_BOOT;
      pc           <= RESET_PC & ~32'd1;
      outstanding  <= '0;
      drop         <= '0;
      o_ir_r       <= THUMB_NOP;
      o_ir_valid_r <= 1'b0;
      o_pc_r       <= '0;
    end else if (is_branch) begin
      // Everything in flight, including a request granted right now, is owed.
      pc           <= i_branch_target & ~32'd1;
      outstanding  <= '0;
      drop         <= drop_branch;
      o_ir_r       <= THUMB_NOP;
      o_ir_valid_r <= 1'b0;
      state        <= (drop_branch != '0) ? ST_FLUSH : ST_FETCH;
    end else begin
      if (grant) pc <= pc + 32'd2;
      outstanding <= out_next;
      drop        <= drop_next;
      case (state)
        ST_BOOT:  state <= ST_FETCH;
        ST_FLUSH: if (drop_next == '0) state <= ST_FETCH;
        default:  state <= state;
      endcase
      if (i_mode == MODE_RUN) begin
        if (fifo_count != '0) begin
          o_ir_r       <= head.instr;
          o_pc_r       <= head.pc;
          o_ir_valid_r <= 1'b1;
        end else begin
          o_ir_r       <= THUMB_NOP;
          o_ir_valid_r <= 1'b0;
        end
      end
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_stat_fetched_r <= '0;
      o_stat_flush_r   <= '0;
    end else begin
      if (do_push && (o_stat_fetched_r != '1)) o_stat_fetched_r <= o_stat_fetched_r + 32'd1;
      if (is_branch && (o_stat_flush_r != '1)) o_stat_flush_r <= o_stat_flush_r + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; the imem model answers address a with a[15:0].
// Stats checks are compiled in only when FETCH_STATS_EN is defined.
`timescale 1ns/1ps
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  i_mode = 2'd0;
  logic [31:0] i_branch_target = '0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt = 1'b0;
  logic        i_imem_rvalid = 1'b0;
  logic [15:0] i_imem_rdata = '0;
  logic [15:0] o_ir_r;
  logic        o_ir_valid_r;
  logic [31:0] o_pc_r;
`ifdef FETCH_STATS_EN
  logic [31:0] o_stat_fetched_r;
  logic [15:0] o_stat_flush_r;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          gnt_en = 1'b0;
  bit          rsp_en = 1'b0;
  logic [31:0] rsp_q[$];

  always #5 clk = ~clk;

  fetch_unit #(.FIFO_DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_mode          (i_mode),
    .i_branch_target (i_branch_target),
    .o_imem_req      (o_imem_req),
    .o_imem_addr     (o_imem_addr),
    .i_imem_gnt      (i_imem_gnt),
    .i_imem_rvalid   (i_imem_rvalid),
    .i_imem_rdata    (i_imem_rdata),
    .o_ir_r          (o_ir_r),
    .o_ir_valid_r    (o_ir_valid_r),
    .o_pc_r          (o_pc_r)
`ifdef FETCH_STATS_EN
    ,
    .o_stat_fetched_r(o_stat_fetched_r),
    .o_stat_flush_r  (o_stat_flush_r)
`endif
  );

  // imem model: in-order, a granted request is answered in the following cycle
  always @(negedge clk) begin
    logic [31:0] a;
    #1;
    i_imem_gnt    = gnt_en;
    i_imem_rvalid = 1'b0;
    if (rst) begin
      rsp_q.delete();
    end else begin
      if (rsp_en && rsp_q.size() != 0) begin
        a             = rsp_q.pop_front();
        i_imem_rvalid = 1'b1;
        i_imem_rdata  = a[15:0];
      end
      if (o_imem_req && gnt_en) rsp_q.push_back(o_imem_addr);
    end
  end

  task automatic next_valid(output logic [31:0] pc, output logic [15:0] ir, output bit ok);
    ok = 1'b0;
    pc = '0;
    ir = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (o_ir_valid_r === 1'b1) begin
        pc = o_pc_r;
        ir = o_ir_r;
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; gnt_en = 1'b1; rsp_en = 1'b1; i_mode = MODE_RUN;
    repeat (2) @(negedge clk);
    n_cmp++; if (o_ir_r !== 16'hBF00) begin n_bad++; $display("FAIL reset_ir: got %h want bf00", o_ir_r); end
    n_cmp++; if (o_ir_valid_r !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", o_ir_valid_r); end
    n_cmp++; if (o_pc_r !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", o_pc_r); end
    n_cmp++; if (o_imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", o_imem_req); end
  endtask

  task automatic test_run();
    logic [31:0] exp_pc;
    @(negedge clk); rst = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_cmp++; if (o_ir_valid_r !== 1'b0) begin n_bad++; $display("FAIL run_early%0d: valid got %b want 0", c, o_ir_valid_r); end
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_pc = 32'(2 * k);
      n_cmp++;
      if (o_ir_valid_r !== 1'b1 || o_pc_r !== exp_pc || o_ir_r !== exp_pc[15:0]) begin
        n_bad++; $display("FAIL run_word%0d: got v=%b pc=%h ir=%h want v=1 pc=%h ir=%h", k, o_ir_valid_r, o_pc_r, o_ir_r, exp_pc, exp_pc[15:0]);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc;
    i_mode = MODE_STALL;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_cmp++;
      if (o_ir_valid_r !== 1'b1 || o_pc_r !== 32'hA || o_ir_r !== 16'h000A) begin
        n_bad++; $display("FAIL stall_hold%0d: got v=%b pc=%h ir=%h want v=1 pc=a ir=000a", c, o_ir_valid_r, o_pc_r, o_ir_r);
      end
    end
    n_cmp++; if (o_imem_req !== 1'b0) begin n_bad++; $display("FAIL stall_req: got %b want 0", o_imem_req); end
    i_mode = MODE_RUN;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      exp_pc = 32'(12 + 2 * k);
      n_cmp++;
      if (o_ir_valid_r !== 1'b1 || o_pc_r !== exp_pc || o_ir_r !== exp_pc[15:0]) begin
        n_bad++; $display("FAIL resume_word%0d: got v=%b pc=%h ir=%h want v=1 pc=%h", k, o_ir_valid_r, o_pc_r, o_ir_r, exp_pc);
      end
    end
  endtask

  task automatic test_branch();
    logic [31:0] pc, exp_pc;
    logic [15:0] ir;
    bit ok;
    // Starve responses so the FIFO drains and two requests stay in flight.
    rsp_en = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++; if (o_imem_req !== 1'b0) begin n_bad++; $display("FAIL br_req_cap: got %b want 0", o_imem_req); end
    n_cmp++; if (o_ir_valid_r !== 1'b0) begin n_bad++; $display("FAIL br_drained: got %b want 0", o_ir_valid_r); end
    i_mode = MODE_BRANCH; i_branch_target = 32'h0000_0101;
    @(negedge clk);
    n_cmp++; if (o_ir_r !== 16'hBF00 || o_ir_valid_r !== 1'b0) begin n_bad++; $display("FAIL br_nop: got ir=%h v=%b want bf00 0", o_ir_r, o_ir_valid_r); end
    i_mode = MODE_RUN; rsp_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      next_valid(pc, ir, ok);
      exp_pc = 32'h100 + 32'(2 * k);
      n_cmp++;
      if (!ok || pc !== exp_pc || ir !== exp_pc[15:0]) begin
        n_bad++; $display("FAIL br_word%0d: got ok=%b pc=%h ir=%h want pc=%h ir=%h", k, ok, pc, ir, exp_pc, exp_pc[15:0]);
      end
    end
  endtask

  task automatic test_branch_collide();
    logic [31:0] pc, exp_pc;
    logic [15:0] ir;
    bit ok;
    repeat (3) @(negedge clk);
    n_cmp++; if (o_imem_req !== 1'b1) begin n_bad++; $display("FAIL col_req: got %b want 1", o_imem_req); end
    i_mode = MODE_BRANCH; i_branch_target = 32'h0000_2000;
    @(negedge clk);
    n_cmp++; if (o_ir_valid_r !== 1'b0) begin n_bad++; $display("FAIL col_nop: got %b want 0", o_ir_valid_r); end
    i_branch_target = 32'h0000_3000; rsp_en = 1'b0;
    @(negedge clk);
    i_mode = MODE_RUN; rsp_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      next_valid(pc, ir, ok);
      exp_pc = 32'h3000 + 32'(2 * k);
      n_cmp++;
      if (!ok || pc !== exp_pc || ir !== exp_pc[15:0]) begin
        n_bad++; $display("FAIL col_word%0d: got ok=%b pc=%h ir=%h want pc=%h ir=%h", k, ok, pc, ir, exp_pc, exp_pc[15:0]);
      end
    end
  endtask

  task automatic test_wrap_reset();
    logic [31:0] pc, exp_pc;
    logic [15:0] ir;
    bit ok;
    i_mode = MODE_BRANCH; i_branch_target = 32'hFFFF_FFFC;
    @(negedge clk);
    i_mode = MODE_RUN;
    for (int k = 0; k < 3; k++) begin
      next_valid(pc, ir, ok);
      exp_pc = 32'hFFFF_FFFC + 32'(2 * k);
      n_cmp++;
      if (!ok || pc !== exp_pc || ir !== exp_pc[15:0]) begin
        n_bad++; $display("FAIL wrap_word%0d: got ok=%b pc=%h ir=%h want pc=%h ir=%h", k, ok, pc, ir, exp_pc, exp_pc[15:0]);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (o_ir_r !== 16'hBF00) begin n_bad++; $display("FAIL rst2_ir: got %h want bf00", o_ir_r); end
    n_cmp++; if (o_ir_valid_r !== 1'b0) begin n_bad++; $display("FAIL rst2_valid: got %b want 0", o_ir_valid_r); end
    n_cmp++; if (o_pc_r !== 32'h0) begin n_bad++; $display("FAIL rst2_pc: got %h want 0", o_pc_r); end
    n_cmp++; if (o_imem_req !== 1'b0) begin n_bad++; $display("FAIL rst2_req: got %b want 0", o_imem_req); end
  endtask

`ifdef FETCH_STATS_EN
  task automatic test_stats();
    rst = 1'b1; i_mode = MODE_STALL; gnt_en = 1'b1; rsp_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    n_cmp++; if (o_stat_fetched_r !== 32'd4) begin n_bad++; $display("FAIL stat_fetch1: got %0d want 4", o_stat_fetched_r); end
    n_cmp++; if (o_stat_flush_r !== 16'd0) begin n_bad++; $display("FAIL stat_flush1: got %0d want 0", o_stat_flush_r); end
    i_mode = MODE_BRANCH; i_branch_target = 32'h0000_0400;
    @(negedge clk);
    i_mode = MODE_STALL;
    repeat (12) @(negedge clk);
    n_cmp++; if (o_stat_fetched_r !== 32'd8) begin n_bad++; $display("FAIL stat_fetch2: got %0d want 8", o_stat_fetched_r); end
    n_cmp++; if (o_stat_flush_r !== 16'd1) begin n_bad++; $display("FAIL stat_flush2: got %0d want 1", o_stat_flush_r); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_run();
    test_stall();
    test_branch();
    test_branch_collide();
    test_wrap_reset();
`ifdef FETCH_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
